// File: rtl/oc_add_scheduler.sv
// Round-robin sequencer for one shared ones' complement ripple adder; result 1 cycle after accept, 2 with end-around carry.
// rsp_ready low holds the response and keeps both requesters stalled; one operation in flight.
module oc_add_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_id,
    output logic             rsp_eac,
    output logic [7:0]       eac_cnt
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             id_q, id_d, eac_q, eac_d, ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             grant0, grant1;
    logic [WIDTH-1:0] add_x, add_y, add_s;
    logic             add_ci, add_cout;

    // The single shared adder; PASS2 reuses it with the end-around carry as carry-in.
    always_comb begin
        logic c;
        c     = add_ci;
        add_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            add_s[i] = add_x[i] ^ add_y[i] ^ c;
            c        = (add_x[i] & add_y[i]) | (c & (add_x[i] ^ add_y[i]));
        end
        add_cout = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= 1'b0;
            eac_q   <= 1'b0;
            ptr_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            eac_q   <= eac_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0_valid || req1_valid) state_d = PASS1;
            PASS1:   state_d = add_cout ? PASS2 : RESP;
            PASS2:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Pointer holds the last-served requester; the other one wins a tie.
        grant0 = req0_valid && (!req1_valid || ptr_q);
        grant1 = req1_valid && (!req0_valid || !ptr_q);
        req0_ready = (state_q == IDLE) && grant0;
        req1_ready = (state_q == IDLE) && grant1;

        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        id_d  = id_q;
        eac_d = eac_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;

        add_x  = a_q;
        add_y  = b_q;
        add_ci = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    a_d  = req0_a;
                    b_d  = req0_b;
                    id_d = 1'b0;
                end else if (req1_ready) begin
                    a_d  = req1_a;
                    b_d  = req1_b;
                    id_d = 1'b1;
                end
            end
            PASS1: begin
                sum_d = add_s;
                eac_d = 1'b0;
            end
            PASS2: begin
                // Carry-out cannot occur here: PASS1 sum is at most all-ones minus one.
                add_x  = sum_q;
                add_y  = '0;
                add_ci = 1'b1;
                sum_d  = add_s;
                eac_d  = 1'b1;
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
            RESP: begin
                if (rsp_ready) ptr_d = id_q;
            end
            default: ;
        endcase

        rsp_valid = (state_q == RESP);
        rsp_sum   = sum_q;
        rsp_id    = id_q;
        rsp_eac   = eac_q;
        eac_cnt   = cnt_q;
    end

endmodule
